gray_step_decoder: RTL and testbench

//  Receiving end of the 2-bit up/down counter's LED output. Samples the Gray-coded

---
 rtl/gray_step_decoder.sv | 137 +++++++++++++
 tb/tb_gray_step_decoder.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_decoder.sv
// Gray-code step decoder: synchronises a 2-bit Gray input and tracks up/down steps.
// Optional macro DEBOUNCE_EN adds a stability filter after the synchroniser.
module gray_step_decoder #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned ERR_W           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [1:0]       gray_in,
    output logic             step_up,
    output logic             step_dn,
    output logic             err,
    output logic             dir,
    output logic [WIDTH-1:0] position,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {StInit, StTrack} state_t;

    logic [1:0] s1, s2;
    logic       v1, v2;
    logic [1:0] acc_code;
    logic       acc_vld;
    logic [1:0] last_code;
    logic [1:0] delta;
    state_t     state;

    // Valid bits mark when s2 holds a real sample, so INIT never captures the reset value
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            s1 <= gray_in;
            s2 <= s1;
            v1 <= 1'b1;
            v2 <= v1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       cand;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] cnt_next;

    // Count consecutive cycles s2 has shown the same code, saturating at the threshold
    always_comb begin
        cnt_next = stable_cnt;
        if (s2 != cand) begin
            cnt_next = CNT_W'(1);
        end else if (stable_cnt < CNT_MAX) begin
            cnt_next = stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cand       <= 2'b00;
            stable_cnt <= '0;
            acc_code   <= 2'b00;
            acc_vld    <= 1'b0;
        end else if (v2) begin
            cand       <= s2;
            stable_cnt <= cnt_next;
            if (cnt_next == CNT_MAX) begin
                acc_code <= s2;
                acc_vld  <= 1'b1;
            end
        end
    end
`else
    assign acc_code = s2;
    assign acc_vld  = v2;
`endif

    // Index along the up-count cycle 10 -> 00 -> 01 -> 11
    function automatic logic [1:0] code_idx(input logic [1:0] g);
        return {g[0], ~(g[1] ^ g[0])};
    endfunction

    assign delta = code_idx(acc_code) - code_idx(last_code);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= StInit;
            last_code <= 2'b00;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;
            err       <= 1'b0;
            dir       <= 1'b1;
            position  <= '0;
            err_count <= '0;
        end else begin
            step_up <= 1'b0;
            step_dn <= 1'b0;
            err     <= 1'b0;
            case (state)
                StInit: begin
                    if (acc_vld) begin
                        last_code <= acc_code;
                        state     <= StTrack;
                    end
                end
                StTrack: begin
                    last_code <= acc_code;
                    case (delta)
                        2'd1: begin
                            step_up  <= 1'b1;
                            dir      <= 1'b1;
                            position <= position + 1'b1;
                        end
                        2'd3: begin
                            step_dn  <= 1'b1;
                            dir      <= 1'b0;
                            position <= position - 1'b1;
                        end
                        2'd2: begin
                            err <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_step_decoder.sv
// Self-checking bench for gray_step_decoder against an index-arithmetic reference model.
module tb_gray_step_decoder;

    localparam int WIDTH = 8;
    localparam int ERR_W = 8;
    localparam int DEB   = 4;
    localparam int VW    = 4 + WIDTH + ERR_W;
`ifdef DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = LAT + 1;
    localparam logic [VW-1:0] RST_VEC = {4'b0001, {WIDTH{1'b0}}, {ERR_W{1'b0}}};

    logic             CLOCK_50 = 1'b0;
    logic             reset    = 1'b1;
    logic [1:0]       gray_in  = 2'b10;
    logic             step_up, step_dn, err, dir;
    logic [WIDTH-1:0] position;
    logic [ERR_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    gray_step_decoder #(
        .WIDTH(WIDTH),
        .ERR_W(ERR_W),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .gray_in(gray_in),
        .step_up(step_up),
        .step_dn(step_dn),
        .err(err),
        .dir(dir),
        .position(position),
        .err_count(err_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: positions along the 4-code cycle, plain modular arithmetic
    int         m_ns = 0, m_run = 0, m_last = 0, m_pos = 0, m_errc = 0, m_delta = 0;
    logic [1:0] m_h1 = 2'b00, m_h2 = 2'b00, m_prev = 2'b00, m_acc = 2'b00;
    bit         m_acc_v = 0, m_started = 0;
    bit         m_up = 0, m_dn = 0, m_err = 0, m_dir = 1;

    function automatic int idx(input logic [1:0] g);
        case (g)
            2'b10:   return 0;
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_step();
        if (reset) begin
            m_ns = 0; m_run = 0; m_last = 0; m_pos = 0; m_errc = 0;
            m_h1 = 2'b00; m_h2 = 2'b00; m_prev = 2'b00; m_acc = 2'b00;
            m_acc_v = 0; m_started = 0;
            m_up = 0; m_dn = 0; m_err = 0; m_dir = 1;
        end else begin
`ifndef DEBOUNCE_EN
            if (m_ns >= 2) begin
                m_acc   = m_h2;
                m_acc_v = 1;
            end
`endif
            m_up = 0; m_dn = 0; m_err = 0;
            if (m_acc_v) begin
                if (!m_started) begin
                    m_started = 1;
                end else begin
                    m_delta = (idx(m_acc) - m_last + 4) % 4;
                    if (m_delta == 1) begin
                        m_up = 1; m_dir = 1; m_pos = (m_pos + 1) % (1 << WIDTH);
                    end else if (m_delta == 3) begin
                        m_dn = 1; m_dir = 0; m_pos = (m_pos + (1 << WIDTH) - 1) % (1 << WIDTH);
                    end else if (m_delta == 2) begin
                        m_err = 1;
                        if (m_errc < (1 << ERR_W) - 1) m_errc = m_errc + 1;
                    end
                end
                m_last = idx(m_acc);
            end
`ifdef DEBOUNCE_EN
            if (m_ns >= 2) begin
                m_run  = (m_run > 0 && m_h2 == m_prev) ? m_run + 1 : 1;
                m_prev = m_h2;
                if (m_run >= DEB) begin
                    m_acc   = m_h2;
                    m_acc_v = 1;
                end
            end
`endif
            m_h2 = m_h1;
            m_h1 = gray_in;
            m_ns = m_ns + 1;
        end
    endtask

    initial forever begin
        @(posedge CLOCK_50 or posedge reset);
        model_step();
    end

    wire [VW-1:0] act_vec = {step_up, step_dn, err, dir, position, err_count};
    wire [VW-1:0] exp_vec = {m_up, m_dn, m_err, m_dir, m_pos[WIDTH-1:0], m_errc[ERR_W-1:0]};

    // Stimulus only: reset with a given input code, then let INIT settle
    task automatic do_reset(input logic [1:0] code);
        @(negedge CLOCK_50);
        reset   = 1'b1;
        gray_in = code;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (LAT + 2) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        int pulses = 0;
        @(negedge CLOCK_50);
        reset   = 1'b1;
        gray_in = 2'b01;
        repeat (2) @(negedge CLOCK_50);
        checks++;
        if (act_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_values: dut=%h expected=%h", act_vec, RST_VEC);
        end
        reset = 1'b0;
        repeat (10) begin
            @(negedge CLOCK_50);
            pulses += int'(step_up) + int'(step_dn) + int'(err);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_hold_model: dut=%h model=%h t=%0t", act_vec, exp_vec, $time);
            end
        end
        checks++;
        if (pulses != 0 || position !== 0 || dir !== 1'b1 || err_count !== 0) begin
            errors++;
            $display("FAIL reset_hold_state: pulses=%0d pos=%0d dir=%b errc=%0d expected 0/0/1/0",
                     pulses, position, dir, err_count);
        end
    endtask

    task automatic test_count_up();
        logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        do_reset(2'b10);
        foreach (seq[k]) begin
            gray_in = seq[k];
            for (int i = 1; i <= HOLD; i++) begin
                @(negedge CLOCK_50);
                checks++;
                if (act_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL count_up_model: dut=%h model=%h t=%0t", act_vec, exp_vec, $time);
                end
                checks++;
                if (step_up !== (i == LAT)) begin
                    errors++;
                    $display("FAIL count_up_latency: edge %0d step_up=%b expected %b",
                             i, step_up, (i == LAT));
                end
            end
        end
        checks++;
        if (position !== 4 || dir !== 1'b1) begin
            errors++;
            $display("FAIL count_up_final: pos=%0d dir=%b expected 4/1", position, dir);
        end
    endtask

    task automatic test_count_down();
        logic [1:0] seq [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
        int pulses = 0;
        do_reset(2'b10);
        foreach (seq[k]) begin
            gray_in = seq[k];
            repeat (HOLD) begin
                @(negedge CLOCK_50);
                pulses += int'(step_dn);
                checks++;
                if (act_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL count_down_model: dut=%h model=%h t=%0t", act_vec, exp_vec, $time);
                end
            end
            if (k == 0) begin
                checks++;
                if (position !== 255) begin
                    errors++;
                    $display("FAIL count_down_wrap: pos=%0d expected 255", position);
                end
            end
        end
        checks++;
        if (pulses != 4 || position !== 252 || dir !== 1'b0) begin
            errors++;
            $display("FAIL count_down_final: pulses=%0d pos=%0d dir=%b expected 4/252/0",
                     pulses, position, dir);
        end
    endtask

    task automatic test_illegal();
        int errs = 0;
        int ups  = 0;
        do_reset(2'b00);
        gray_in = 2'b11;
        repeat (HOLD) begin
            @(negedge CLOCK_50);
            errs += int'(err);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL illegal_model: dut=%h model=%h t=%0t", act_vec, exp_vec, $time);
            end
        end
        checks++;
        if (errs != 1 || err_count !== 1 || position !== 0) begin
            errors++;
            $display("FAIL illegal_jump: errs=%0d errc=%0d pos=%0d expected 1/1/0",
                     errs, err_count, position);
        end
        gray_in = 2'b10;
        repeat (HOLD) begin
            @(negedge CLOCK_50);
            ups += int'(step_up);
        end
        checks++;
        if (ups != 1 || position !== 1 || err_count !== 1) begin
            errors++;
            $display("FAIL illegal_then_up: ups=%0d pos=%0d errc=%0d expected 1/1/1",
                     ups, position, err_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] seq [7] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
        int pulses = 0;
        do_reset(2'b10);
        foreach (seq[k]) begin
            gray_in = seq[k];
            repeat (HOLD) @(negedge CLOCK_50);
        end
        checks++;
        if (position !== 7) begin
            errors++;
            $display("FAIL reset_mid_pre: pos=%0d expected 7", position);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (act_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_mid_async: dut=%h expected=%h", act_vec, RST_VEC);
        end
        gray_in = 2'b11;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (LAT + 3) begin
            @(negedge CLOCK_50);
            pulses += int'(step_up) + int'(step_dn) + int'(err);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_mid_model: dut=%h model=%h t=%0t", act_vec, exp_vec, $time);
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid_recapture: pulses=%0d expected 0", pulses);
        end
        gray_in = 2'b10;
        repeat (HOLD) @(negedge CLOCK_50);
        checks++;
        if (position !== 1 || dir !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_step: pos=%0d dir=%b expected 1/1", position, dir);
        end
    endtask

    task automatic test_err_saturation();
        do_reset(2'b10);
        for (int k = 0; k < 270; k++) begin
            gray_in = (k % 2 == 0) ? 2'b01 : 2'b10;
            repeat (HOLD) @(negedge CLOCK_50);
            if (k == 100) begin
                checks++;
                if (act_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL err_sat_model: dut=%h model=%h", act_vec, exp_vec);
                end
            end
        end
        checks++;
        if (err_count !== 255 || position !== 0) begin
            errors++;
            $display("FAIL err_saturation: errc=%0d pos=%0d expected 255/0", err_count, position);
        end
    endtask

    task automatic test_random();
        do_reset(2'($urandom_range(0, 3)));
        repeat (400) begin
            if ($urandom_range(0, 9) < 4) gray_in = 2'($urandom_range(0, 3));
            @(negedge CLOCK_50);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL random_model: dut=%h model=%h t=%0t", act_vec, exp_vec, $time);
            end
        end
    endtask

`ifdef DEBOUNCE_EN
    task automatic test_debounce();
        int pulses = 0;
        do_reset(2'b10);
        gray_in = 2'b00;
        repeat (2) @(negedge CLOCK_50);
        gray_in = 2'b10;
        repeat (10) begin
            @(negedge CLOCK_50);
            pulses += int'(step_up) + int'(step_dn) + int'(err);
        end
        checks++;
        if (pulses != 0 || position !== 0) begin
            errors++;
            $display("FAIL debounce_glitch: pulses=%0d pos=%0d expected 0/0", pulses, position);
        end
        gray_in = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLOCK_50);
            checks++;
            if (step_up !== (i == DEB + 3)) begin
                errors++;
                $display("FAIL debounce_latency: edge %0d step_up=%b expected %b",
                         i, step_up, (i == DEB + 3));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_illegal();
        test_reset_mid();
        test_err_saturation();
        test_random();
`ifdef DEBOUNCE_EN
        test_debounce();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
